// File: rtl/punc_mem_pkg.sv
// Shared types and default widths for the PUnC memory arbiter slice.
package punc_mem_pkg;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 16;

   // Arbiter phase: loader-exclusive boot, then CPU-priority run
   typedef enum logic {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Which port receives the data of an outstanding read
   typedef enum logic {
      OWN_C = 1'b0,
      OWN_L = 1'b1
   } owner_e;

endpackage

// File: rtl/punc_starve_ctr.sv
// Saturating up-counter with synchronous clear and a flag raised at its limit.
// Used to track how long the loader has been refused a memory slot.
module punc_starve_ctr #(
   parameter int LIMIT = 4,
   parameter int WIDTH = $clog2(LIMIT + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic at_limit
);

   localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // Next count: clear wins, otherwise count up but never past the limit
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != LIMIT_V)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register, cleared asynchronously by the active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_limit = (cnt_q == LIMIT_V);

endmodule

// File: rtl/punc_mem_arbiter.sv
// Two-port arbiter in front of the unified PUnC memory. Port C is the CPU,
// port L is the program loader / debug host. During boot only L may access
// memory and the CPU is held off; after boot_done the CPU has priority, but
// the loader is guaranteed a slot after STARVE_LIMIT consecutive refusals.
module punc_mem_arbiter
   import punc_mem_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic              c_gnt,
   output logic              c_rvalid,
   output logic [DATA_W-1:0] c_rdata,
   input  logic              l_req,
   input  logic              l_we,
   input  logic [ADDR_W-1:0] l_addr,
   input  logic [DATA_W-1:0] l_wdata,
   output logic              l_gnt,
   output logic              l_rvalid,
   output logic [DATA_W-1:0] l_rdata,
   input  logic              boot_done,
   output logic              cpu_run,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [CNT_W-1:0]  c_wait_cnt
);

   state_e              state_q, state_d;
   logic                cpu_run_q, cpu_run_d;
   logic                rd_pend_q, rd_pend_d;
   owner_e              rd_own_q, rd_own_d;
   logic [DATA_W-1:0]   c_rdata_q, c_rdata_d;
   logic [DATA_W-1:0]   l_rdata_q, l_rdata_d;
   logic [CNT_W-1:0]    c_wait_q, c_wait_d;

   logic                starve_clr;
   logic                starve_inc;
   logic                starve_full;

   // Loader starvation tracking only matters in RUN; in BOOT L always wins
   punc_starve_ctr #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk      (clk),
      .rst      (rst),
      .clr      (starve_clr),
      .inc      (starve_inc),
      .at_limit (starve_full)
   );

   // Grant decision: combinational from requests and phase, suppressed in reset
   always_comb begin
      c_gnt = 1'b0;
      l_gnt = 1'b0;
      if (rst) begin
         if (state_q == ST_BOOT) begin
            l_gnt = l_req;
         end else if (l_req && starve_full) begin
            l_gnt = 1'b1;
         end else if (c_req) begin
            c_gnt = 1'b1;
         end else begin
            l_gnt = l_req;
         end
      end
   end

   // Starvation counter control: count refused loader cycles in RUN only
   always_comb begin
      starve_inc = (state_q == ST_RUN) && l_req && !l_gnt;
      starve_clr = !starve_inc;
   end

   // Memory issue: the granted port drives the memory in the same cycle
   always_comb begin
      mem_en    = c_gnt || l_gnt;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (c_gnt) begin
         mem_we    = c_we;
         mem_addr  = c_addr;
         mem_wdata = c_wdata;
      end else if (l_gnt) begin
         mem_we    = l_we;
         mem_addr  = l_addr;
         mem_wdata = l_wdata;
      end
   end

   // Read return: route the memory word to the owner, others hold their last data
   always_comb begin
      c_rvalid = rd_pend_q && (rd_own_q == OWN_C);
      l_rvalid = rd_pend_q && (rd_own_q == OWN_L);
      c_rdata  = c_rvalid ? mem_rdata : c_rdata_q;
      l_rdata  = l_rvalid ? mem_rdata : l_rdata_q;
   end

   // Next-state values for the phase, read-tracking and wait-counter registers
   always_comb begin
      state_d   = state_q;
      if ((state_q == ST_BOOT) && boot_done) begin
         state_d = ST_RUN;
      end
      cpu_run_d = (state_d == ST_RUN);

      rd_pend_d = (c_gnt && !c_we) || (l_gnt && !l_we);
      rd_own_d  = c_gnt ? OWN_C : OWN_L;
      c_rdata_d = c_rdata;
      l_rdata_d = l_rdata;

      c_wait_d  = c_wait_q;
      if (c_req && !c_gnt && (c_wait_q != {CNT_W{1'b1}})) begin
         c_wait_d = c_wait_q + 1'b1;
      end
   end

   // All arbiter state; reset drops any outstanding read and returns to BOOT
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_BOOT;
         cpu_run_q <= 1'b0;
         rd_pend_q <= 1'b0;
         rd_own_q  <= OWN_C;
         c_rdata_q <= '0;
         l_rdata_q <= '0;
         c_wait_q  <= '0;
      end else begin
         state_q   <= state_d;
         cpu_run_q <= cpu_run_d;
         rd_pend_q <= rd_pend_d;
         rd_own_q  <= rd_own_d;
         c_rdata_q <= c_rdata_d;
         l_rdata_q <= l_rdata_d;
         c_wait_q  <= c_wait_d;
      end
   end

   assign cpu_run    = cpu_run_q;
   assign c_wait_cnt = c_wait_q;

endmodule
